// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types and helpers for the BCD counter run controller.
package bcd_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Widest chain the digit checker handles; narrower vectors are zero-padded.
  localparam int MAX_DIGITS = 8;

  function automatic logic bcd_valid(input logic [4*MAX_DIGITS-1:0] vec);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < MAX_DIGITS; d++) begin
      if (vec[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// Count-tick prescaler: counts 0..DIV-1 while enabled, tick on the last count.
module bcd_tick_gen #(
  parameter int DIV   = 50000,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (en) begin
      if (cnt == LAST)      cnt <= '0;
      else                  cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run controller for a cascaded BCD counter chain: prescaled count ticks,
// chain clear requests and stop-on-target compare.
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter int DIV    = 50000,
  parameter int DIV_W  = 16,
  parameter int DIGITS = 3
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  Clear,
  input  logic [4*DIGITS-1:0]   Target,
  input  logic [4*DIGITS-1:0]   Q_in,
  input  logic                  Cout_in,
  output logic                  Cin_out,
  output logic                  Cnt_clr,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Ovf,
  output logic                  Target_err
);

  // state | meaning
  // IDLE  | waiting for Start with a valid target
  // RUN   | prescaler running, ticks feed the chain, compare armed after 1st cycle
  // PAUSE | prescaler frozen at its current count, no ticks
  // DONE  | chain reached the target, waiting for Start or Clear

  localparam int BCD_W = 4 * DIGITS;

  state_t                  state, state_nx;
  logic [BCD_W-1:0]        target_q;
  logic [4*MAX_DIGITS-1:0] target_ext;
  logic                    cmp_en, match, tgt_ok, arm;
  logic                    pre_en, pre_clr, tick;
  logic                    cin_d, clr_d, busy_d, done_d, ovf_d, terr_d;

  always_comb begin
    target_ext = '0;
    target_ext[BCD_W-1:0] = Target;
  end

  assign tgt_ok = bcd_valid(target_ext);
  assign arm    = !Clear && Start && tgt_ok && (state == ST_IDLE || state == ST_DONE);
  // Chain clear lands at the end of the first RUN cycle, so the compare waits one cycle.
  assign match  = (state == ST_RUN) && cmp_en && (Q_in == target_q);

  assign pre_en  = (state == ST_RUN) && !Clear && !Stop && !match;
  assign pre_clr = Clear || (state == ST_IDLE) || (state == ST_DONE);

  bcd_tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk  (Clk),
    .rst  (Rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_IDLE;
      target_q   <= '0;
      cmp_en     <= 1'b0;
      Cin_out    <= 1'b0;
      Cnt_clr    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Ovf        <= 1'b0;
      Target_err <= 1'b0;
    end else begin
      state      <= state_nx;
      if (arm) target_q <= Target;
      cmp_en     <= (state == ST_RUN) || (state == ST_PAUSE);
      Cin_out    <= cin_d;
      Cnt_clr    <= clr_d;
      Busy       <= busy_d;
      Done       <= done_d;
      Ovf        <= ovf_d;
      Target_err <= terr_d;
    end
  end

  always_comb begin
    state_nx = state;
    if (Clear) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (arm) state_nx = ST_RUN;
        ST_RUN: begin
          if (Stop)       state_nx = ST_PAUSE;
          else if (match) state_nx = ST_DONE;
        end
        ST_PAUSE:         if (Start && !Stop) state_nx = ST_RUN;
        default:          state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cin_d  = tick;
    clr_d  = Clear || arm;
    busy_d = (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
    done_d = (state_nx == ST_DONE);
    ovf_d  = Clear ? 1'b0 : (Ovf || (Cin_out && Cout_in));
    terr_d = !tgt_ok;
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: directed table, corner-case sequences and random
// commands against a behavioural controller model driving a BCD chain model.
module tb_bcd_count_ctrl;

  localparam int DIV    = 4;
  localparam int DIV_W  = 4;
  localparam int DIGITS = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        Clk = 1'b0;
  logic        Rst, Start, Stop, Clear;
  logic [11:0] Target, Q_in;
  logic        Cout_in, Cin_out, Cnt_clr, Busy, Done, Ovf, Target_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          m_mode, m_count, m_age;
  logic [11:0] m_tgt;
  logic        m_cin, m_clr, m_busy, m_done, m_ovf, m_terr;

  typedef struct {
    logic        start;
    logic        stop;
    logic        clear;
    logic [11:0] target;
    logic [5:0]  expv;
  } vec_t;

  vec_t tbl[10];

  bcd_count_ctrl #(.DIV(DIV), .DIV_W(DIV_W), .DIGITS(DIGITS)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Stop       (Stop),
    .Clear      (Clear),
    .Target     (Target),
    .Q_in       (Q_in),
    .Cout_in    (Cout_in),
    .Cin_out    (Cin_out),
    .Cnt_clr    (Cnt_clr),
    .Busy       (Busy),
    .Done       (Done),
    .Ovf        (Ovf),
    .Target_err (Target_err)
  );

  always #5 Clk = ~Clk;

  // Most significant decade carries out when the whole chain is at 999 and counts.
  assign Cout_in = Cin_out && (Q_in == 12'h999);

  function automatic int bcd2int(input logic [11:0] v);
    return int'(v[3:0]) + 10 * int'(v[7:4]) + 100 * int'(v[11:8]);
  endfunction

  function automatic logic [11:0] int2bcd(input int n);
    logic [11:0] r;
    r[3:0]  = 4'(n % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[11:8] = 4'((n / 100) % 10);
    return r;
  endfunction

  function automatic bit tgt_valid(input logic [11:0] v);
    for (int d = 0; d < DIGITS; d++)
      if (((v >> (4 * d)) & 12'hF) > 12'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [5:0] outs();
    return {Cin_out, Cnt_clr, Busy, Done, Ovf, Target_err};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_cin, m_clr, m_busy, m_done, m_ovf, m_terr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_count = 0; m_age = 0; m_tgt = '0;
    m_cin = 0; m_clr = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_terr = 0;
  endtask

  // Expected registered outputs for the cycle after the current inputs.
  task automatic model_next();
    bit cin_n, clr_n, ovf_n;
    cin_n = 1'b0;
    clr_n = 1'b0;
    ovf_n = m_ovf || (m_cin && (Q_in == 12'h999));
    if (Clear) begin
      m_mode = M_IDLE;
      clr_n  = 1'b1;
      ovf_n  = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE:
          if (Start && tgt_valid(Target)) begin
            m_tgt = Target; clr_n = 1'b1; m_mode = M_RUN; m_count = 0; m_age = 0;
          end
        M_RUN: begin
          if (Stop) m_mode = M_PAUSE;
          else if (m_age > 0 && Q_in == m_tgt) m_mode = M_DONE;
          else begin
            cin_n = ((m_count % DIV) == DIV - 1);
            m_count++;
          end
          m_age++;
        end
        default: if (Start && !Stop) m_mode = M_RUN;
      endcase
    end
    m_cin  = cin_n;
    m_clr  = clr_n;
    m_ovf  = ovf_n;
    m_busy = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    m_done = (m_mode == M_DONE);
    m_terr = !tgt_valid(Target);
  endtask

  task automatic step(input bit chk_model);
    logic cin_s, clr_s;
    cin_s = Cin_out;
    clr_s = Cnt_clr;
    model_next();
    @(posedge Clk);
    #1;
    if (clr_s)      Q_in = '0;
    else if (cin_s) Q_in = int2bcd((bcd2int(Q_in) + 1) % 1000);
    cyc++;
    if (chk_model) chk("model", 32'(outs()), 32'(exp_vec()));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first, prev, gap_bad, q5, donec, stray, gap;
    bit found;

    Rst = 1'b1; Start = 0; Stop = 0; Clear = 0; Target = '0; Q_in = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_hold", 32'(outs()), 32'd0);
    Rst = 1'b0;
    step(1);

    // {start, stop, clear, target, expected {cin,clr,busy,done,ovf,terr}}
    tbl[0] = '{1'b0, 1'b0, 1'b0, 12'h0A3, 6'b000001};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 12'h0A3, 6'b000001};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 12'h0A3, 6'b000001};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 12'h000, 6'b000000};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 12'h000, 6'b011000};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 12'h000, 6'b001000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 12'h000, 6'b000100};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 12'h000, 6'b000100};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 12'h000, 6'b010000};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 12'h000, 6'b000000};
    for (int i = 0; i < 10; i++) begin
      Start = tbl[i].start; Stop = tbl[i].stop; Clear = tbl[i].clear; Target = tbl[i].target;
      step(1);
      chk($sformatf("table_row%0d", i), 32'(outs()), 32'(tbl[i].expv));
    end
    Start = 0; Stop = 0; Clear = 0;

    // Target 005: tick every DIV cycles, five ticks, Done one cycle after Q_in==005.
    Target = 12'h005; Start = 1; step(1); Start = 0;
    chk("t2_cnt_clr", 32'(Cnt_clr), 32'd1);
    pulses = 0; first = -1; prev = -1; gap_bad = 0; q5 = -1; donec = -1;
    for (int i = 1; i <= 60; i++) begin
      if (donec < 0) begin
        step(1);
        if (Cin_out) begin
          if (first < 0) first = i;
          else if (i - prev != DIV) gap_bad++;
          prev = i;
          pulses++;
        end
        if (Q_in == 12'h005 && q5 < 0) q5 = i;
        if (Done) donec = i;
      end
    end
    chk("t2_done_seen", 32'(donec > 0), 32'd1);
    chk("t2_first_tick", 32'(first), 32'(DIV));
    chk("t2_pulses", 32'(pulses), 32'd5);
    chk("t2_tick_spacing", 32'(gap_bad), 32'd0);
    chk("t2_done_latency", 32'(donec - q5), 32'd1);
    chk("t2_busy_low", 32'(Busy), 32'd0);

    // Target 020 re-armed from DONE: pause mid-count, resume from held prescaler.
    Target = 12'h020; Start = 1; step(1); Start = 0;
    pulses = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        step(1);
        if (Cin_out) pulses++;
        if (pulses == 3) found = 1;
      end
    end
    chk("t3_three_ticks", 32'(found), 32'd1);
    step(1);
    Stop = 1; step(1); Stop = 0;
    chk("t3_paused", 32'({Busy, Done}), 32'd2);
    stray = 0;
    repeat (10) begin step(1); stray += int'(Cin_out); end
    Start = 1; step(1); Start = 0; stray += int'(Cin_out);
    gap = 13; found = 0;
    for (int i = 0; i < 10; i++) begin
      if (!found) begin
        step(1);
        gap++;
        if (Cin_out) found = 1;
      end
    end
    // one running cycle at prescaler 1, 12 stop/pause/start cycles, then counts 1..3
    chk("t3_resume_gap", 32'(gap), 32'd16);
    chk("t3_no_tick_paused", 32'(stray), 32'd0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (!found) begin step(1); if (Done) found = 1; end
    end
    chk("t3_done_seen", 32'(found), 32'd1);
    chk("t3_done_value", 32'(Q_in), 32'h020);

    // Overflow: target 000 with the chain preset to 999 after its clear.
    Clear = 1; step(1); Clear = 0;
    Target = 12'h000; Start = 1; step(1); Start = 0;
    step(1);
    Q_in = 12'h999;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin step(1); if (Done) found = 1; end
    end
    chk("t5_done_after_wrap", 32'(found), 32'd1);
    chk("t5_ovf_set", 32'(Ovf), 32'd1);
    Target = 12'h001; Start = 1; step(1); Start = 0;
    chk("t5_ovf_sticky_start", 32'({Ovf, Cnt_clr}), 32'd3);
    Clear = 1; step(1); Clear = 0;
    chk("t5_ovf_cleared", 32'({Ovf, Cnt_clr}), 32'd1);

    // Clear, Stop and Start together while running.
    Target = 12'h050; Start = 1; step(1); Start = 0;
    repeat (3) step(1);
    Clear = 1; Stop = 1; Start = 1; step(1);
    Clear = 0; Stop = 0; Start = 0;
    chk("t6_clear_wins", 32'({Cnt_clr, Busy, Done, Cin_out}), 32'h8);
    step(1);
    chk("t6_idle", 32'({Cnt_clr, Busy, Done}), 32'd0);

    // Asynchronous reset in the middle of a run.
    Target = 12'h050; Start = 1; step(1); Start = 0;
    repeat (5) step(1);
    chk("t1_running", 32'(Busy), 32'd1);
    #2 Rst = 1'b1;
    #1 chk("t1_async_reset", 32'(outs()), 32'd0);
    model_reset();
    Q_in = '0;
    @(posedge Clk);
    #1 Rst = 1'b0;
    step(1);
    Target = 12'h002; Start = 1; step(1); Start = 0;
    chk("t1_restart_from_idle", 32'({Cnt_clr, Busy}), 32'd3);

    // Random command stream against the model.
    for (int i = 0; i < 3000; i++) begin
      Clear  = ($urandom_range(0, 99) == 0);
      Stop   = ($urandom_range(0, 29) == 0);
      Start  = ($urandom_range(0, 7) == 0);
      Target = int2bcd(int'($urandom_range(0, 30)));
      if ($urandom_range(0, 9) == 0) Target[7:4] = 4'hB;
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
